ps2_link_ctrl: RTL and testbench

Sequences the PS/2 clock/data pad pair for the PS/2 peripheral. Owns the open-drain line drivers, decides per frame whether the link receives (device-to-host) or transmits (host-to-device), and buffers received scan-code bytes in a small FIFO. Sits between the pads and the AXI4-Lite register shell, which writes commands through tx_* and drains bytes through rx_*.

---
 rtl/ps2_link_ctrl_if.sv | 12 +
 rtl/ps2_link_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_link_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_link_ctrl_if.sv
// Register-shell side handshakes of the PS/2 link: command bytes in, scan-code bytes out.
interface ps2_link_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid);
    modport slave  (input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/ps2_link_ctrl.sv
// PS/2 pad sequencer: filtered input path, per-frame RX/TX state machine with
// open-drain pad enables, and a small RX byte FIFO with sticky error flags.
module ps2_link_ctrl #(
    parameter int INHIBIT_CYC = 10000,
    parameter int TIMEOUT_CYC = 200000,
    parameter int FILT_LEN    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic ps2_clk_oe,
    output logic ps2_data_oe,
    ps2_link_ctrl_if.slave bus,
    output logic busy,
    output logic err_parity,
    output logic err_overflow,
    output logic err_timeout,
    output logic err_nack,
    input  logic err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {IDLE, RX, TX_INH, TX_BITS, TX_ACK, TX_END} state_t;

    // bit 0 = clock, bit 1 = data
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] filt_cnt [2];
    logic          clk_prev, clk_f, data_f, fall;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
        end else begin
            sync1    <= {ps2_data_i, ps2_clk_i};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + FW'(1);
                end
            end
        end
    end

    assign clk_f  = filt[0];
    assign data_f = filt[1];
    assign fall   = clk_prev & ~clk_f;

    state_t        state, state_n;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [8:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic          tx_par, drv_low;
    logic          ready, accept, rx_shift, push, set_par, set_nack, set_to, tx_step;
    logic          inh_last, to_hit, rx_ok;

    assign inh_last = (inh_cnt == IW'(INHIBIT_CYC - 1));
    assign to_hit   = (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign rx_ok    = (^rx_sh) & data_f;

    always_comb begin
        state_n  = state;
        ready    = 1'b0;
        accept   = 1'b0;
        rx_shift = 1'b0;
        push     = 1'b0;
        set_par  = 1'b0;
        set_nack = 1'b0;
        set_to   = 1'b0;
        tx_step  = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_f) begin
                    state_n = RX;
                end else if (!fall && data_f) begin
                    ready = 1'b1;
                    if (bus.tx_valid) begin
                        accept  = 1'b1;
                        state_n = TX_INH;
                    end
                end
            end
            RX: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        push    = rx_ok;
                        set_par = ~rx_ok;
                        state_n = IDLE;
                    end else begin
                        rx_shift = 1'b1;
                    end
                end else if (to_hit) begin
                    set_to  = 1'b1;
                    state_n = IDLE;
                end
            end
            TX_INH: if (inh_last) state_n = TX_BITS;
            TX_BITS: begin
                if (fall) begin
                    tx_step = 1'b1;
                    if (bit_cnt == 4'd9) state_n = TX_ACK;
                end else if (to_hit) begin
                    set_to  = 1'b1;
                    state_n = IDLE;
                end
            end
            TX_ACK: begin
                if (fall) begin
                    set_nack = data_f;
                    state_n  = TX_END;
                end else if (to_hit) begin
                    set_to  = 1'b1;
                    state_n = IDLE;
                end
            end
            TX_END: begin
                if (clk_f && data_f) begin
                    state_n = IDLE;
                end else if (to_hit) begin
                    set_to  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // RX FIFO; one extra pointer bit distinguishes full from empty
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, pop, push_ok, ovf;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = bus.rx_valid & bus.rx_ready;
    assign push_ok = push & (~full | pop);
    assign ovf     = push & full & ~pop;

    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wptr[AW-1:0]] <= rx_sh[7:0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            inh_cnt      <= '0;
            to_cnt       <= '0;
            rx_sh        <= '0;
            tx_sh        <= '0;
            tx_par       <= 1'b0;
            drv_low      <= 1'b0;
            wptr         <= '0;
            rptr         <= '0;
            err_parity   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            err_nack     <= 1'b0;
        end else begin
            state   <= state_n;
            inh_cnt <= (state == TX_INH) ? inh_cnt + IW'(1) : '0;
            if (state_n != state || fall || state == IDLE || state == TX_INH)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);
            if (state_n != state)
                bit_cnt <= '0;
            else if (fall && (state == RX || state == TX_BITS))
                bit_cnt <= bit_cnt + 4'd1;
            if (rx_shift) rx_sh <= {data_f, rx_sh[8:1]};
            if (accept) begin
                tx_sh  <= bus.tx_data;
                tx_par <= ~^bus.tx_data;
            end
            if (state == TX_INH && state_n == TX_BITS) begin
                drv_low <= 1'b1;
            end else if (tx_step) begin
                if (bit_cnt < 4'd8) begin
                    drv_low <= ~tx_sh[0];
                    tx_sh   <= tx_sh >> 1;
                end else if (bit_cnt == 4'd8) begin
                    drv_low <= ~tx_par;
                end else begin
                    drv_low <= 1'b0;
                end
            end
            if (push_ok) wptr <= wptr + (AW+1)'(1);
            if (pop)     rptr <= rptr + (AW+1)'(1);
            err_parity   <= set_par  | (err_parity   & ~err_clr);
            err_overflow <= ovf      | (err_overflow & ~err_clr);
            err_timeout  <= set_to   | (err_timeout  & ~err_clr);
            err_nack     <= set_nack | (err_nack     & ~err_clr);
        end
    end

    assign busy         = (state != IDLE);
    assign ps2_clk_oe   = (state == TX_INH);
    assign ps2_data_oe  = (state == TX_INH && inh_last) || (state == TX_BITS && drv_low);
    assign bus.tx_ready = ready & ~ARESET;
    assign bus.rx_valid = (wptr != rptr);
    assign bus.rx_data  = bus.rx_valid ? mem[rptr[AW-1:0]] : 8'h00;
endmodule

// File: tb/tb_ps2_link_ctrl.sv
// Bench for ps2_link_ctrl: device-side PS/2 model, RX/TX scoreboards, RX frame table.
module tb_ps2_link_ctrl;
    localparam int INH = 20;
    localparam int TMO = 500;
    localparam int FL  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic ps2_clk, ps2_data;
    logic clk_oe, data_oe, busy;
    logic err_parity, err_overflow, err_timeout, err_nack;
    logic err_clr = 1'b0;

    ps2_link_ctrl_if bus();

    assign ps2_clk  = dev_clk  & ~clk_oe;
    assign ps2_data = dev_data & ~data_oe;

    ps2_link_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(FL), .FIFO_DEPTH(4)) dut (
        .ACLK(clk), .ARESET(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .bus(bus), .busy(busy),
        .err_parity(err_parity), .err_overflow(err_overflow), .err_timeout(err_timeout),
        .err_nack(err_nack), .err_clr(err_clr));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int mon_bad = 0;
    logic mon_en = 1'b0;
    logic [7:0] sb_rx[$];
    logic       sb_tx[$];

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic       exp_push;
        logic       exp_perr;
    } rx_vec_t;
    rx_vec_t vecs[5];

    // TX must never start while an RX frame is in flight
    always @(negedge clk) if (mon_en && clk_oe) mon_bad++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_errs();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data = fr[i];
            cyc(10);
            dev_clk = 1'b0;
            cyc(20);
            dev_clk = 1'b1;
            cyc(10);
        end
        dev_data = 1'b1;
        cyc(5);
    endtask

    task automatic pop_check(input string name);
        check({name, "_valid"}, bus.rx_valid, 1);
        if (sb_rx.size() == 0) check({name, "_sb_empty"}, 0, 1);
        else check(name, bus.rx_data, sb_rx.pop_front());
        bus.rx_ready = 1'b1;
        cyc(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic push_tx_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sb_tx.push_back(b[i]);
        sb_tx.push_back(~^b);
        sb_tx.push_back(1'b1);
    endtask

    // accept a command, then verify the inhibit window cycle by cycle
    task automatic host_tx(input logic [7:0] b);
        int bad_clk, bad_data, t;
        bad_clk = 0; bad_data = 0; t = 0;
        while (!bus.tx_ready && t < 200) begin cyc(1); t++; end
        check("tx_ready_idle", bus.tx_ready, 1);
        push_tx_bits(b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        cyc(1);
        bus.tx_valid = 1'b0;
        for (int k = 0; k < INH; k++) begin
            if (clk_oe !== 1'b1) bad_clk++;
            if (data_oe !== (k == INH - 1)) bad_data++;
            cyc(1);
        end
        check("inh_clk_oe_cycles", bad_clk, 0);
        check("inh_data_oe_cycles", bad_data, 0);
    endtask

    task automatic device_recv(input logic ack);
        int t;
        logic got;
        t = 0;
        while (clk_oe && t < 100) begin cyc(1); t++; end
        check("tx_inh_released", clk_oe, 0);
        check("tx_start_bit", data_oe, 1);
        cyc(10);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            cyc(19);
            got = ps2_data;
            if (sb_tx.size() == 0) check("tx_sb_empty", 0, 1);
            else check($sformatf("tx_bit%0d", i), got, sb_tx.pop_front());
            cyc(1);
            dev_clk = 1'b1;
            cyc(20);
        end
        dev_data = ack;
        cyc(10);
        dev_clk = 1'b0;
        cyc(20);
        dev_clk = 1'b1;
        cyc(10);
        dev_data = 1'b1;
        t = 0;
        while (busy && t < 100) begin cyc(1); t++; end
        check("tx_busy_done", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        cyc(3);
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", bus.tx_ready, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_errs", {err_parity, err_overflow, err_timeout, err_nack}, 0);
        rst = 1'b0;
        cyc(8);
        check("idle_tx_ready", bus.tx_ready, 1);

        // RX frame table
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop, 11);
            if (vecs[v].exp_push) sb_rx.push_back(vecs[v].data);
            check($sformatf("vec%0d_perr", v), err_parity, vecs[v].exp_perr);
            check($sformatf("vec%0d_valid", v), bus.rx_valid, vecs[v].exp_push);
            if (vecs[v].exp_push) begin
                pop_check($sformatf("vec%0d_data", v));
                check($sformatf("vec%0d_empty", v), bus.rx_valid, 0);
            end
            if (vecs[v].exp_perr) begin
                clr_errs();
                check($sformatf("vec%0d_perr_clr", v), err_parity, 0);
            end
        end

        // overflow: fifth byte dropped
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b0, 1'b1, 11);
            if (b <= 4) sb_rx.push_back(8'(b));
            if (b == 4) check("ovf_not_yet", err_overflow, 0);
        end
        check("ovf_set", err_overflow, 1);
        for (int b = 1; b <= 4; b++) pop_check($sformatf("ovf_pop%0d", b));
        check("ovf_drained", bus.rx_valid, 0);
        clr_errs();
        check("ovf_clr", err_overflow, 0);

        // TX with ACK, then with NACK
        host_tx(8'hFF);
        device_recv(1'b0);
        check("tx_ff_nack", err_nack, 0);
        host_tx(8'h3C);
        device_recv(1'b1);
        check("tx_3c_nack", err_nack, 1);
        clr_errs();
        check("nack_clr", err_nack, 0);

        // device stops clocking after start + 3 bits
        begin
            int t;
            send_frame(8'h0F, 1'b0, 1'b1, 4);
            check("to_busy_rx", busy, 1);
            t = 0;
            while (!err_timeout && t < 700) begin cyc(1); t++; end
            check("to_set", err_timeout, 1);
            check("to_latency", (t >= 440 && t <= 510), 1);
            check("to_idle", busy, 0);
            check("to_pads", {clk_oe, data_oe}, 0);
            check("to_no_push", bus.rx_valid, 0);
            clr_errs();
            check("to_clr", err_timeout, 0);
        end

        // reset in the middle of TX_BITS
        host_tx(8'h00);
        cyc(10);
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0; cyc(20);
            dev_clk = 1'b1; cyc(20);
        end
        check("rstmid_busy", busy, 1);
        check("rstmid_data_oe", data_oe, 1);
        rst = 1'b1;
        cyc(1);
        check("rstmid_pads", {clk_oe, data_oe}, 0);
        check("rstmid_idle", busy, 0);
        rst = 1'b0;
        sb_tx.delete();
        cyc(8);
        check("rstmid_tx_ready", bus.tx_ready, 1);

        // command raised as the device starts a frame: RX first, TX afterwards
        begin
            logic accepted;
            accepted = 1'b0;
            dev_data = 1'b0;
            cyc(6);
            check("coin_tx_ready_low", bus.tx_ready, 0);
            push_tx_bits(8'h96);
            sb_rx.push_back(8'h5A);
            bus.tx_data  = 8'h96;
            bus.tx_valid = 1'b1;
            mon_en = 1'b1;
            begin
                logic [10:0] fr;
                fr = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    dev_data = fr[i];
                    cyc(10); dev_clk = 1'b0; cyc(20); dev_clk = 1'b1; cyc(10);
                end
            end
            mon_en = 1'b0;
            check("coin_no_tx_during_rx", mon_bad, 0);
            dev_data = 1'b1;
            cyc(10);
            dev_clk = 1'b0;
            for (int i = 0; i < 20; i++) begin
                cyc(1);
                if (bus.tx_valid && clk_oe) begin bus.tx_valid = 1'b0; accepted = 1'b1; end
            end
            dev_clk = 1'b1;
            check("coin_tx_accepted", accepted, 1);
            pop_check("coin_rx_byte");
            device_recv(1'b0);
            check("coin_nack", err_nack, 0);
            check("coin_perr", err_parity, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
